// File: rtl/sram_read_seq_if.sv
// Bus bundle for the SRAM read sequencer.
// slave = sequencer side, master = requester/SRAM side.
interface sram_read_seq_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              Req;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] SRAM_DQ;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              CE_N;
  logic              OE_N;
  logic              WE_N;
  logic [DATA_W-1:0] Data_out;
  logic              Valid;
  logic              Busy;
  logic [15:0]       Read_count;

  modport slave (
    input  Req, Addr, SRAM_DQ,
    output SRAM_ADDR, CE_N, OE_N, WE_N,
    output Data_out, Valid, Busy, Read_count
  );

  modport master (
    output Req, Addr, SRAM_DQ,
    input  SRAM_ADDR, CE_N, OE_N, WE_N,
    input  Data_out, Valid, Busy, Read_count
  );
endinterface

// File: rtl/sram_read_seq.sv
// SRAM read sequencer: strobes, fixed wait, capture, valid pulse.
// Optional completed-read counter: SRAM_READ_SEQ_COUNT_EN.
module sram_read_seq #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_read_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ce_n;
  logic              oe_n;
  logic              valid;
  logic              busy;

  // Sequencer FSM with all outputs registered alongside state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      ce_n   <= 1'b1;
      oe_n   <= 1'b1;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Req) begin
            addr_q <= bus.Addr;
            ce_n   <= 1'b0;
            oe_n   <= 1'b0;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST)
            state <= CAPTURE;
        end
        CAPTURE: begin
          data_q <= bus.SRAM_DQ;
          ce_n   <= 1'b1;
          oe_n   <= 1'b1;
          valid  <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ce_n  <= 1'b1;
          oe_n  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_READ_SEQ_COUNT_EN
  logic [15:0] read_cnt;

  // Count reads on the edge entering DONE; aborted reads never get there.
  always_ff @(posedge Clk) begin
    if (Reset)
      read_cnt <= '0;
    else if (state == CAPTURE)
      read_cnt <= read_cnt + 16'd1;
  end

  assign bus.Read_count = read_cnt;
`else
  assign bus.Read_count = 16'h0000;
`endif

  assign bus.SRAM_ADDR = addr_q;
  assign bus.CE_N      = ce_n;
  assign bus.OE_N      = oe_n;
  assign bus.WE_N      = 1'b1;
  assign bus.Data_out  = data_q;
  assign bus.Valid     = valid;
  assign bus.Busy      = busy;

endmodule

// File: tb/tb_sram_read_seq.sv
// Bench for sram_read_seq: timing model keyed on edges since acceptance.
// Extra instances cover WAIT_CYCLES = 1 and 15.
module tb_sram_read_seq;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sram_read_seq_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  sram_read_seq_if #(.ADDR_W(20), .DATA_W(16)) b1 ();
  sram_read_seq_if #(.ADDR_W(20), .DATA_W(16)) b15 ();

  sram_read_seq #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .Clk(clk), .Reset(rst), .bus(bus.slave)
  );
  sram_read_seq #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(rst), .bus(b1.slave)
  );
  sram_read_seq #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(15)) dut15 (
    .Clk(clk), .Reset(rst), .bus(b15.slave)
  );

  int passed = 0;
  int total  = 0;

  // reference model state: edge index and edge of last acceptance
  int          e      = 0;
  int          acc    = -1000;
  logic [19:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_cnt  = '0;

  task automatic tick();
    @(posedge clk);
    e++;
    if (rst) begin
      acc    = -1000;
      m_addr = '0;
      m_data = '0;
      m_cnt  = '0;
    end else begin
      if ((e - 1 - acc) >= W + 3 && bus.Req) begin
        acc    = e;
        m_addr = bus.Addr;
      end
      if (e - acc == W + 2) begin
        m_data = bus.SRAM_DQ;
`ifdef SRAM_READ_SEQ_COUNT_EN
        m_cnt = m_cnt + 16'd1;
`endif
      end
    end
    #1;
  endtask

  function automatic logic [56:0] exp_vec();
    int   rel;
    logic sl;
    rel = e - acc;
    sl  = (rel >= 0) && (rel <= W + 1);
    return {~sl, ~sl, 1'b1, rel == W + 2, (rel >= 0) && (rel <= W + 2),
            m_addr, m_data, m_cnt};
  endfunction

  function automatic logic [56:0] obs_vec();
    return {bus.CE_N, bus.OE_N, bus.WE_N, bus.Valid, bus.Busy,
            bus.SRAM_ADDR, bus.Data_out, bus.Read_count};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.Req = 1'b0;
    tick();
    total++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL idle%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_directed();
    int lows = 0;
    int vals = 0;
    bus.Req     = 1'b1;
    bus.Addr    = 20'h00123;
    bus.SRAM_DQ = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.Req  = 1'b0;
      bus.Addr = 20'($urandom);
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL directed c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      if (!bus.CE_N) lows++;
      if (bus.Valid) vals++;
    end
    total++;
    if (lows !== 4)
      $display("FAIL strobe_len: got %0d want 4", lows);
    else passed++;
    total++;
    if (vals !== 1)
      $display("FAIL valid_cnt: got %0d want 1", vals);
    else passed++;
    total++;
    if (bus.Data_out !== 16'hBEEF || bus.SRAM_ADDR !== 20'h00123)
      $display("FAIL directed_data: got %h/%h want beef/00123",
               bus.Data_out, bus.SRAM_ADDR);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int vals = 0;
    int want = (20 + W + 3) / (W + 4);
    for (int i = 0; i < 28; i++) begin
      bus.Req     = (i < 20);
      bus.Addr    = 20'($urandom);
      bus.SRAM_DQ = 16'($urandom);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL b2b c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      if (bus.Valid) vals++;
    end
    bus.Req = 1'b0;
    total++;
    if (vals !== want)
      $display("FAIL b2b_valids: got %0d want %0d", vals, want);
    else passed++;
  endtask

  task automatic test_reset_wait();
    bus.Req     = 1'b1;
    bus.Addr    = 20'($urandom);
    bus.SRAM_DQ = 16'($urandom);
    tick();
    bus.Req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (obs_vec() !== exp_vec() || bus.Data_out !== 16'h0)
      $display("FAIL reset_wait: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL post_abort c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.Req     = ($urandom % 3 == 0);
      bus.Addr    = 20'($urandom);
      bus.SRAM_DQ = 16'($urandom);
      rst         = ($urandom % 50 == 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL rand c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    rst = 1'b0;
    bus.Req = 1'b0;
    repeat (W + 4) tick();
  endtask

  task automatic test_count();
`ifdef SRAM_READ_SEQ_COUNT_EN
    force dut.read_cnt = 16'hFFFF;
    #1;
    release dut.read_cnt;
    m_cnt = 16'hFFFF;
    bus.Req = 1'b1;
    tick();
    bus.Req = 1'b0;
    repeat (W + 3) tick();
    total++;
    if (bus.Read_count !== 16'h0000 || obs_vec() !== exp_vec())
      $display("FAIL count_wrap: got %h want 0000", bus.Read_count);
    else passed++;
`else
    for (int r = 0; r < 3; r++) begin
      bus.Req = 1'b1;
      tick();
      bus.Req = 1'b0;
      repeat (W + 3) tick();
    end
    total++;
    if (bus.Read_count !== 16'h0000 || obs_vec() !== exp_vec())
      $display("FAIL count_off: got %h want 0000", bus.Read_count);
    else passed++;
`endif
  endtask

  task automatic test_wait_params();
    logic [15:0] g1  = 16'($urandom);
    logic [15:0] g15 = 16'($urandom);
    for (int k = 0; k < 22; k++) begin
      b1.Req      = (k == 0);
      b15.Req     = (k == 0);
      b1.Addr     = 20'($urandom);
      b15.Addr    = 20'($urandom);
      b1.SRAM_DQ  = (k == 3)  ? g1  : ~g1;
      b15.SRAM_DQ = (k == 17) ? g15 : ~g15;
      tick();
      total++;
      if (b1.Valid !== (k == 3))
        $display("FAIL w1_valid e%0d: got %b want %b", k, b1.Valid, k == 3);
      else passed++;
      total++;
      if (b15.Valid !== (k == 17))
        $display("FAIL w15_valid e%0d: got %b want %b", k, b15.Valid, k == 17);
      else passed++;
    end
    b1.Req  = 1'b0;
    b15.Req = 1'b0;
    total++;
    if (b1.Data_out !== g1)
      $display("FAIL w1_data: got %h want %h", b1.Data_out, g1);
    else passed++;
    total++;
    if (b15.Data_out !== g15)
      $display("FAIL w15_data: got %h want %h", b15.Data_out, g15);
    else passed++;
  endtask

  initial begin
    bus.Req = 1'b0; bus.Addr = '0; bus.SRAM_DQ = '0;
    b1.Req  = 1'b0; b1.Addr  = '0; b1.SRAM_DQ  = '0;
    b15.Req = 1'b0; b15.Addr = '0; b15.SRAM_DQ = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_wait();
    test_random();
    test_count();
    test_wait_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
